// File: rtl/ntlm_pkg.sv
// ntlm_pkg: shared types and constants for the NTLM brute-force search engine.
//   CHARSET_SIZE  number of symbols per password position ('a'..'z', '0'..'9')
//   MAX_LEN       longest password the engine enumerates (core length port is 4 bits)
//   COUNT_W       width of the tried counter (36^8 < 2^42)
//   hash_t        128-bit digest / packed candidate string
//   digit_t       one odometer digit (charset index 0..35)
//   state_t       search FSM states
//   idx2ascii     charset index -> ASCII byte
package ntlm_pkg;

    localparam int CHARSET_SIZE = 36;
    localparam int MAX_LEN      = 8;
    localparam int COUNT_W      = 42;

    typedef logic [127:0] hash_t;
    typedef logic [5:0]   digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam digit_t DIGIT_MAX = digit_t'(CHARSET_SIZE - 1);

    // 0..25 -> 'a'..'z', 26..35 -> '0'..'9'
    function automatic logic [7:0] idx2ascii(digit_t d);
        if (d < 6'd26) begin
            return 8'h61 + {2'b00, d};
        end else begin
            return 8'h30 + {2'b00, d} - 8'd26;
        end
    endfunction

endpackage

// File: rtl/ntlm_cand_odometer.sv
// ntlm_cand_odometer: base-36 odometer that enumerates candidate passwords.
//   clk, rst  rising-edge clock, synchronous active-high reset
//   clr       zero every digit (start of a new search)
//   inc       advance to the next candidate (digit 0 is least significant)
//   len       number of active digits / characters
//   cand      packed candidate: char k in bits [127-8k -: 8], bytes >= len are 0
//   wrap      all active digits are at 35, i.e. cand is the last candidate
module ntlm_cand_odometer
    import ntlm_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [3:0]   len,
    output logic [127:0] cand,
    output logic         wrap
);

    digit_t digit [MAX_LEN];
    digit_t nxt   [MAX_LEN];
    logic   carry;

    // Ripple the increment through the active digits. The running carry is
    // "every lower active digit is at 35", which after the last active digit
    // is exactly the wrap condition.
    always_comb begin
        carry = 1'b1;
        cand  = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            nxt[k] = digit[k];
            if (4'(k) < len) begin
                if (carry) begin
                    nxt[k] = (digit[k] == DIGIT_MAX) ? '0 : digit[k] + 6'd1;
                end
                carry = carry && (digit[k] == DIGIT_MAX);
                cand[127 - 8*k -: 8] = idx2ascii(digit[k]);
            end
        end
        wrap = carry;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                digit[k] <= '0;
            end
        end else if (inc) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                digit[k] <= nxt[k];
            end
        end
    end

endmodule

// File: rtl/ntlm_search_ctrl.sv
// ntlm_search_ctrl: brute-force sequencer around a combinational NTLM core.
// Issues one candidate per clock, registers the returned digest (stage 1),
// compares it with the latched target and reports the first match or
// exhaustion of the search space.
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start        begin a search (sampled in IDLE only)
//   abort        cancel a running search, no done pulse
//   pw_len       password length, latched on start (legal 1..MAX_LEN)
//   target_hash  digest to find, latched on start
//   cand         candidate string to the core
//   cand_len     latched length, drives the core length port
//   core_hash    core digest of cand (combinational return path)
//   busy         high in RUN and DRAIN
//   done         one-cycle pulse at the end of a search (match, exhaustion, error)
//   found        match flag, valid from done until the next accepted start
//   found_pw     matching candidate, same packing as cand
//   error        illegal pw_len at start, held until the next accepted start
//   tried        number of digests compared in this search (saturating)
//   dbg_state    current FSM state
//
// Handshake: start is a level sampled on a clock edge while IDLE; the search
// is accepted on that edge. done is a single-cycle pulse with found, found_pw,
// error and tried valid in the same cycle and held afterwards.
module ntlm_search_ctrl
    import ntlm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         pw_len,
    input  logic [127:0]       target_hash,
    output logic [127:0]       cand,
    output logic [3:0]         cand_len,
    input  logic [127:0]       core_hash,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [127:0]       found_pw,
    output logic               error,
    output logic [COUNT_W-1:0] tried,
    output logic [1:0]         dbg_state
);

    state_t state;
    hash_t  target_q;
    hash_t  s1_hash;
    hash_t  s1_cand;
    logic   s1_v;

    logic   len_ok;
    logic   match;
    logic   wrap;
    logic   odo_clr;
    logic   odo_inc;

    assign len_ok  = (pw_len != 4'd0) && (pw_len <= 4'(MAX_LEN));
    assign match   = s1_v && (s1_hash == target_q);
    assign odo_clr = (state == IDLE) && start && len_ok;
    // Issue stops immediately on a match or abort; the final candidate is
    // held on cand through DRAIN.
    assign odo_inc = (state == RUN) && !abort && !match && !wrap;

    assign dbg_state = state;

    ntlm_cand_odometer u_odometer (
        .clk  (clk),
        .rst  (rst),
        .clr  (odo_clr),
        .inc  (odo_inc),
        .len  (cand_len),
        .cand (cand),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            target_q <= '0;
            s1_hash  <= '0;
            s1_cand  <= '0;
            s1_v     <= 1'b0;
            cand_len <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            found    <= 1'b0;
            found_pw <= '0;
            error    <= 1'b0;
            tried    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s1_v <= 1'b0;
                    if (start) begin
                        if (len_ok) begin
                            target_q <= target_hash;
                            cand_len <= pw_len;
                            found    <= 1'b0;
                            found_pw <= '0;
                            error    <= 1'b0;
                            tried    <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            done  <= 1'b1;
                            error <= 1'b1;
                            found <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        // abort outranks a same-cycle match; that compare is dropped
                        s1_v  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (s1_v && (tried != {COUNT_W{1'b1}})) begin
                            tried <= tried + COUNT_W'(1);
                        end
                        if (match) begin
                            // the candidate on cand this cycle is discarded
                            found    <= 1'b1;
                            found_pw <= s1_cand;
                            done     <= 1'b1;
                            s1_v     <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            s1_hash <= core_hash;
                            s1_cand <= cand;
                            s1_v    <= 1'b1;
                            if (wrap) begin
                                state <= DRAIN;
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        s1_v  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (s1_v && (tried != {COUNT_W{1'b1}})) begin
                            tried <= tried + COUNT_W'(1);
                        end
                        if (match) begin
                            found    <= 1'b1;
                            found_pw <= s1_cand;
                        end
                        done  <= 1'b1;
                        s1_v  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    s1_v  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntlm_search_ctrl.sv
// tb_ntlm_search_ctrl: directed and randomized checks of ntlm_search_ctrl.
// The NTLM core is replaced by a bijective scrambler of the candidate so that
// every candidate has a unique digest and a target can be built from any
// password. Expected candidates come from base-36 arithmetic on the
// candidate index.
module tb_ntlm_search_ctrl;
    import ntlm_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [3:0]         pw_len;
    logic [127:0]       target_hash;
    logic [127:0]       cand;
    logic [3:0]         cand_len;
    logic [127:0]       core_hash;
    logic               busy;
    logic               done;
    logic               found;
    logic [127:0]       found_pw;
    logic               error;
    logic [COUNT_W-1:0] tried;
    logic [1:0]         dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stand-in core ----------------
    function automatic logic [127:0] fake_hash(input logic [127:0] c);
        logic [127:0] r;
        r = {c[90:0], c[127:91]};
        return r ^ 128'h3c5a_96e1_0f87_d2b4_6a19_e5c3_7b08_f24d;
    endfunction

    assign core_hash = fake_hash(cand);

    ntlm_search_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .pw_len      (pw_len),
        .target_hash (target_hash),
        .cand        (cand),
        .cand_len    (cand_len),
        .core_hash   (core_hash),
        .busy        (busy),
        .done        (done),
        .found       (found),
        .found_pw    (found_pw),
        .error       (error),
        .tried       (tried),
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    // Candidate number idx of a length-len search: base-36 digits of idx,
    // least significant digit in character 0.
    function automatic logic [127:0] model_cand(input int len, input longint idx);
        logic [127:0] s;
        longint       r;
        int           d;
        s = '0;
        r = idx;
        for (int k = 0; k < len; k++) begin
            d = int'(r % 36);
            r = r / 36;
            s[127 - 8*k -: 8] = (d < 26) ? 8'(8'h61 + d) : 8'(8'h30 + d - 26);
        end
        return s;
    endfunction

    function automatic longint space(input int len);
        longint s;
        s = 1;
        for (int k = 0; k < len; k++) s = s * 36;
        return s;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cand"},     cand,            '0);
        check({tag, "_cand_len"}, 128'(cand_len),  '0);
        check({tag, "_busy"},     128'(busy),      '0);
        check({tag, "_done"},     128'(done),      '0);
        check({tag, "_found"},    128'(found),     '0);
        check({tag, "_found_pw"}, found_pw,        '0);
        check({tag, "_error"},    128'(error),     '0);
        check({tag, "_tried"},    128'(tried),     '0);
    endtask

    // Start a legal search and follow it to done. match_idx < 0 means the
    // target is not in the space. busy_start_cyc > 0 pulses start with a
    // different length in that cycle, which must be ignored.
    task automatic run_search(input string tag, input int len, input logic [127:0] tgt,
                              input longint match_idx, input int busy_start_cyc,
                              output logic [127:0] fpw);
        longint             n_total;
        longint             last_cyc;
        longint             exp_done;
        longint             done_cyc;
        logic [COUNT_W-1:0] exp_tried;
        logic               found_s;
        logic               error_s;
        logic [COUNT_W-1:0] tried_s;
        n_total  = space(len);
        done_cyc = -1;
        found_s  = 1'b0;
        error_s  = 1'b0;
        tried_s  = '0;
        fpw      = '0;
        if (match_idx >= 0) begin
            exp_done  = match_idx + 3;
            last_cyc  = match_idx + 1;
            exp_tried = COUNT_W'(match_idx + 1);
        end else begin
            exp_done  = n_total + 2;
            last_cyc  = n_total + 1;
            exp_tried = COUNT_W'(n_total);
        end
        start       = 1'b1;
        pw_len      = 4'(len);
        target_hash = tgt;
        step();
        start       = 1'b0;
        target_hash = {$urandom, $urandom, $urandom, $urandom};
        for (longint c = 1; c <= exp_done + 3 && done_cyc < 0; c++) begin
            if (c == longint'(busy_start_cyc)) begin
                start  = 1'b1;
                pw_len = (len == 1) ? 4'd2 : 4'd1;
            end
            @(negedge clk);
            if (c <= last_cyc) begin
                check({tag, "_cand"}, cand, model_cand(len, (c <= n_total) ? c - 1 : n_total - 1));
            end
            if (done) begin
                done_cyc = c;
                found_s  = found;
                fpw      = found_pw;
                error_s  = error;
                tried_s  = tried;
                check({tag, "_busy_at_done"}, 128'(busy), '0);
            end else begin
                check({tag, "_busy"}, 128'(busy), 128'(1'b1));
            end
            step();
            start = 1'b0;
        end
        check({tag, "_done_seen"},  128'(done_cyc >= 0), 128'(1'b1));
        check({tag, "_done_cycle"}, 128'(done_cyc),      128'(exp_done));
        check({tag, "_found"},      128'(found_s),       128'(match_idx >= 0));
        check({tag, "_found_pw"},   fpw, (match_idx >= 0) ? model_cand(len, match_idx) : 128'(0));
        check({tag, "_error"},      128'(error_s),       '0);
        check({tag, "_tried"},      128'(tried_s),       128'(exp_tried));
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(done),          '0);
        check({tag, "_found_hold"}, 128'(found),         128'(match_idx >= 0));
        check({tag, "_tried_hold"}, 128'(tried),         128'(exp_tried));
        step();
    endtask

    task automatic illegal_start(input string tag, input int len);
        start       = 1'b1;
        pw_len      = 4'(len);
        target_hash = {$urandom, $urandom, $urandom, $urandom};
        step();
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done"},  128'(done),  128'(1'b1));
        check({tag, "_error"}, 128'(error), 128'(1'b1));
        check({tag, "_found"}, 128'(found), '0);
        check({tag, "_busy"},  128'(busy),  '0);
        step();
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(done),  '0);
        check({tag, "_error_hold"}, 128'(error), 128'(1'b1));
        check({tag, "_busy_after"}, 128'(busy),  '0);
        step();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] fpw;
        logic [127:0] fpw_keep;
        longint       idx;
        int           len;
        int           abort_c;

        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        pw_len      = '0;
        target_hash = '0;
        repeat (3) step();
        @(negedge clk);
        check_all_zero("reset");
        step();
        rst = 1'b0;
        step();

        // length 1, target "c": found at cycle 5 with tried 3
        run_search("len1_c", 1, fake_hash(model_cand(1, 2)), 2, 0, fpw);
        check("len1_c_byte", 128'(fpw[127:120]), 128'(8'h63));

        // abort while idle changes nothing
        fpw_keep = found_pw;
        abort    = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_found",    128'(found), 128'(1'b1));
        check("idle_abort_found_pw", found_pw,    fpw_keep);
        check("idle_abort_busy",     128'(busy),  '0);
        check("idle_abort_done",     128'(done),  '0);
        step();

        // illegal lengths
        illegal_start("len0", 0);
        illegal_start("len9", 9);
        illegal_start("len_big", $urandom_range(10, 15));

        // exhaustion of length 1 with an unreachable target
        run_search("len1_exhaust", 1, '0, -1, 0, fpw);

        // "a0": char0 = 'a' (0), char1 = '0' (26); start pulsed while busy
        run_search("len2_a0", 2, fake_hash(model_cand(2, 26 * 36)), 26 * 36, 5, fpw);
        check("len2_a0_str", 128'(fpw[127:112]), 128'(16'h6130));

        // exhaustion of length 2, exercising DRAIN after a full carry chain
        run_search("len2_exhaust", 2, '0, -1, 0, fpw);

        // random targets
        for (int i = 0; i < 5; i++) begin
            len = $urandom_range(1, 2);
            idx = longint'($urandom_range(0, 32'(space(len) - 1)));
            run_search("rand", len, fake_hash(model_cand(len, idx)), idx, $urandom_range(0, 8), fpw);
        end
        idx = longint'($urandom_range(0, 3000));
        run_search("rand_len3", 3, fake_hash(model_cand(3, idx)), idx, 0, fpw);

        // abort in RUN: compares completed before the abort cycle are kept
        abort_c     = $urandom_range(3, 20);
        start       = 1'b1;
        pw_len      = 4'd3;
        target_hash = fake_hash(model_cand(3, 40000));
        step();
        start = 1'b0;
        for (int c = 1; c < abort_c; c++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_busy",  128'(busy),  '0);
            check("abort_done",  128'(done),  '0);
            check("abort_found", 128'(found), '0);
            check("abort_error", 128'(error), '0);
            check("abort_tried", 128'(tried), 128'(abort_c - 2));
            step();
        end
        run_search("after_abort_a", 1, fake_hash(model_cand(1, 0)), 0, 0, fpw);

        // reset in the middle of a length-2 search
        start       = 1'b1;
        pw_len      = 4'd2;
        target_hash = fake_hash(model_cand(2, 1200));
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        step();
        @(negedge clk);
        check("mid_reset_done_after", 128'(done), '0);
        check("mid_reset_busy_after", 128'(busy), '0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
